vec_vsetvl_unit: RTL and testbench
==================================

Name: vec_vsetvl_unit

Overview:
Executes the vector configuration instructions vsetvli, vsetivli and vsetvl.
- Accepts an instruction and its scalar operands from the scalar processor over a valid/ready handshake.
- Computes the new vtype and vl (AVL clamped to VLMAX), then drives the write side of the vector CSR register file (vtype_o, vl_o, csrwr_en).
- Returns the new vl to the scalar processor as the rd writeback value over a response handshake.

Parameters:
XLEN, 32, scalar/CSR data width
VLEN, 512, vector register length in bits (power of two, 64..4096)

Ports:
clk  in  1  clock
n_rst  in  1  reset; asynchronous, active-low
inst_i  in  XLEN  instruction word
rs1_i  in  XLEN  value of rs1 (AVL)
rs2_i  in  XLEN  value of rs2 (vtype for vsetvl)
inst_valid_i  in  1  instruction valid
inst_ready_o  out  1  unit can accept an instruction
cur_vl_i  in  XLEN  current vl from the CSR regfile
vtype_o  out  XLEN  new vtype to the CSR regfile
vl_o  out  XLEN  new vl to the CSR regfile
csrwr_en  out  1  one-cycle CSR write strobe
resp_valid_o  out  1  response valid
resp_ready_i  in  1  scalar processor accepts the response
rd_data_o  out  XLEN  value written to rd (new vl)
rd_addr_o  out  5  destination register
illegal_o  out  1  instruction not a vset* (valid with the response)

Behaviour:
- Reset values: every output is 0, except inst_ready_o=1. State is IDLE. Reset is honoured in any state and drops any in-flight instruction; no csrwr_en is issued for it.
- FSM states: IDLE, DECODE, CALC, WRITE, RESP.
- IDLE:
  - inst_ready_o=1.
  - On inst_valid_i, latch inst_i, rs1_i, rs2_i → DECODE.
  - inst_ready_o=0 in every other state.
- DECODE:
  - Legal only if opcode=7'h57 and funct3=3'b111.
  - vsetvli: inst[31]=0; zimm=inst[30:20]; AVL=rs1_i.
  - vsetivli: inst[31:30]=2'b11; zimm=inst[29:20]; AVL=zero-extended inst[19:15].
  - vsetvl: inst[31:25]=7'b1000000; vtype source=rs2_i; AVL=rs1_i.
  - Any other encoding: illegal → RESP with illegal_o=1, rd_data_o=0, no CSR write.
  - Otherwise → CALC.
- vtype fields (bit positions): vlmul[2:0], vsew[5:3], vta[6], vma[7].
- vill is set when any of the following holds:
  - vsew > 3;
  - vlmul[2]=1 (fractional LMUL and the reserved encoding are unsupported);
  - any source vtype bit above bit 7 is nonzero.
- CALC:
  - VLMAX = (VLEN << vlmul) >> (vsew+3), computed with shifts only.
  - Legal, vsetvli/vsetvl, rs1 field ≠ x0: vl = min(AVL, VLMAX).
  - Legal, rs1 field = x0, rd field ≠ x0: vl = VLMAX.
  - Legal, rs1 field = x0, rd field = x0: vl = min(cur_vl_i, VLMAX).
  - Legal, vsetivli: vl = min(uimm, VLMAX). The rs1=x0 rules do not apply; uimm=0 gives vl=0.
  - Legal result: vtype_o = {0…, vma, vta, vsew, vlmul}.
  - vill result: vtype_o = 1<<(XLEN-1), vl=0.
  - → WRITE.
- WRITE:
  - csrwr_en=1 for exactly one cycle; vtype_o and vl_o are stable in that cycle and held afterwards.
  - → RESP.
- RESP:
  - resp_valid_o=1; rd_data_o=vl; rd_addr_o=inst[11:7].
  - Outputs are held while resp_ready_i=0.
  - On resp_ready_i=1 → IDLE.
- Latency: accept → csrwr_en is 3 cycles; earliest resp_valid_o is 4 cycles after accept. Throughput is at most one instruction per 5 cycles.
- An inst_valid_i asserted while busy is ignored; the producer holds it until inst_ready_o=1.

Decomposition:
- Shared package vec_de_csr_defs, extended with:
  - the OPV opcode and OPCFG funct3 constants;
  - vset_kind_e {VSETVLI, VSETIVLI, VSETVL, VSET_ILL};
  - a vset_state_e enum.
- Reuse the existing vtype struct, vlmul_e and vew_e from that package.
- One natural sub-module: vec_vlmax_calc. It is combinational and maps (vsew, vlmul, avl, mode) to (vlmax, vl, vill).

Test Plan:
- Directed scenarios, all with VLEN=512:
  1. vsetvli x5,x6,e32,m1 with rs1=10 → csrwr_en pulse 3 cycles after accept; vl_o=10; vtype_o=0x10; rd_data_o=10; rd_addr_o=5.
  2. vsetvli e8,m8 with rs1=1000 → VLMAX=512, vl_o=512. Repeat with rs1=100 → vl_o=100.
  3. vsetvli x7,x0,e64,m2 → vl_o=16. Then vsetvli x0,x0,e64,m1 with cur_vl_i=16 → vl_o=8.
  4. vsetivli uimm=5, e16,m1,ta,ma → vl_o=5, vtype_o=0xC8. Repeat with uimm=0 → vl_o=0.
  5. vsetvl with rs2=0x20 (vsew=4) → vtype_o=0x80000000, vl_o=0, rd_data_o=0. Non-vset instruction (opcode 0x33) → illegal_o=1 and no csrwr_en.
  6. Hold resp_ready_i=0 for 10 cycles → resp_valid_o and rd_data_o stable, inst_ready_o=0. Then assert n_rst low during CALC → all outputs 0 and inst_ready_o=1 immediately, with no csrwr_en.

Source files
------------

// File: rtl/vec_de_csr_defs.sv
// +-----------------------------------------------------------------------+
// | vec_de_csr_defs : vector CSR types shared by decode and CSR units     |
// | Rev 1.1 - vset* opcode constants, instruction kinds and FSM states    |
// +-----------------------------------------------------------------------+
`default_nettype none

package vec_de_csr_defs;

  typedef enum logic [2:0] {
    LMUL_1 = 3'd0, LMUL_2 = 3'd1, LMUL_4 = 3'd2, LMUL_8 = 3'd3,
    LMUL_RSVD = 3'd4, LMUL_F8 = 3'd5, LMUL_F4 = 3'd6, LMUL_F2 = 3'd7
  } vlmul_e;

  typedef enum logic [2:0] {
    EW_8 = 3'd0, EW_16 = 3'd1, EW_32 = 3'd2, EW_64 = 3'd3,
    EW_128 = 3'd4, EW_256 = 3'd5, EW_512 = 3'd6, EW_1024 = 3'd7
  } vew_e;

  typedef struct packed {
    logic   vma;
    logic   vta;
    vew_e   vsew;
    vlmul_e vlmul;
  } vtype_t;

  localparam logic [6:0] OPV_OPCODE   = 7'h57;
  localparam logic [2:0] OPCFG_FUNCT3 = 3'b111;

  typedef enum logic [1:0] {
    VSETVLI  = 2'd0,
    VSETIVLI = 2'd1,
    VSETVL   = 2'd2,
    VSET_ILL = 2'd3
  } vset_kind_e;

  typedef enum logic [2:0] {
    VS_IDLE   = 3'd0,
    VS_DECODE = 3'd1,
    VS_CALC   = 3'd2,
    VS_WRITE  = 3'd3,
    VS_RESP   = 3'd4
  } vset_state_e;

endpackage

`default_nettype wire

// File: rtl/vec_vsetvl_unit_vlmax.sv
// +-----------------------------------------------------------------------+
// | vec_vlmax_calc : combinational VLMAX, vl clamp and vill detection     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module vec_vlmax_calc
  import vec_de_csr_defs::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned VLEN = 512
) (
  input  logic [2:0]      vsew,
  input  logic [2:0]      vlmul,
  input  logic            rsvd_nz,
  input  logic [XLEN-1:0] avl,
  input  logic            mode,
  output logic [XLEN-1:0] vl,
  output logic            vill
);

  localparam logic [XLEN-1:0] VLEN_W = XLEN'(VLEN);

  logic [2:0]      sew_sh;
  logic [XLEN-1:0] vlmax;

  // Only integer LMUL 1..8 reaches here legally, so VLEN<<3 fits any XLEN>=16.
  assign sew_sh = {1'b0, vsew[1:0]} + 3'd3;
  assign vlmax  = (VLEN_W << vlmul[1:0]) >> sew_sh;
  assign vill   = (vsew > EW_64) | vlmul[2] | rsvd_nz;

  always_comb begin
    vl = '0;
    if (!vill) begin
      if (mode)            vl = vlmax;
      else if (avl < vlmax) vl = avl;
      else                 vl = vlmax;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vec_vsetvl_unit.sv
// +-----------------------------------------------------------------------+
// | vec_vsetvl_unit : executes vsetvli / vsetivli / vsetvl                 |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module vec_vsetvl_unit
  import vec_de_csr_defs::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned VLEN = 512
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [XLEN-1:0] inst_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            inst_valid_i,
  output logic            inst_ready_o,
  input  logic [XLEN-1:0] cur_vl_i,
  output logic [XLEN-1:0] vtype_o,
  output logic [XLEN-1:0] vl_o,
  output logic            csrwr_en,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            illegal_o
);

  vset_state_e     state_q, state_d;
  vset_kind_e      kind_q, kind_d, dec_kind;
  logic [XLEN-1:0] inst_q, inst_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [XLEN-1:0] vtype_q, vtype_d, vl_q, vl_d, rd_data_q, rd_data_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] src_vtype, calc_avl, calc_vl;
  logic            calc_mode, calc_vill, rs1_zero, rd_zero;
  vtype_t          vt;

  always_comb begin
    dec_kind = VSET_ILL;
    if (inst_q[6:0] == OPV_OPCODE && inst_q[14:12] == OPCFG_FUNCT3) begin
      if (!inst_q[31])                   dec_kind = VSETVLI;
      else if (inst_q[31:30] == 2'b11)   dec_kind = VSETIVLI;
      else if (inst_q[31:25] == 7'h40)   dec_kind = VSETVL;
    end
  end

  assign rs1_zero = (inst_q[19:15] == 5'd0);
  assign rd_zero  = (inst_q[11:7] == 5'd0);

  // AVL source and clamp mode; the x0 shortcuts only exist for the register-AVL forms.
  always_comb begin
    src_vtype = XLEN'(inst_q[30:20]);
    calc_avl  = rs1_q;
    calc_mode = 1'b0;
    case (kind_q)
      VSETIVLI: begin
        src_vtype = XLEN'(inst_q[29:20]);
        calc_avl  = XLEN'(inst_q[19:15]);
      end
      VSETVL:  src_vtype = rs2_q;
      default: src_vtype = XLEN'(inst_q[30:20]);
    endcase
    if (kind_q != VSETIVLI && rs1_zero) begin
      if (!rd_zero) calc_mode = 1'b1;
      else          calc_avl  = cur_vl_i;
    end
  end

  assign vt = vtype_t'(src_vtype[7:0]);

  vec_vlmax_calc #(
    .XLEN (XLEN),
    .VLEN (VLEN)
  ) u_vlmax (
    .vsew    (vt.vsew),
    .vlmul   (vt.vlmul),
    .rsvd_nz (|src_vtype[XLEN-1:8]),
    .avl     (calc_avl),
    .mode    (calc_mode),
    .vl      (calc_vl),
    .vill    (calc_vill)
  );

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    inst_d    = inst_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    vtype_d   = vtype_q;
    vl_d      = vl_q;
    rd_data_d = rd_data_q;
    illegal_d = illegal_q;
    case (state_q)
      VS_IDLE: begin
        if (inst_valid_i) begin
          inst_d  = inst_i;
          rs1_d   = rs1_i;
          rs2_d   = rs2_i;
          state_d = VS_DECODE;
        end
      end
      VS_DECODE: begin
        kind_d = dec_kind;
        if (dec_kind == VSET_ILL) begin
          illegal_d = 1'b1;
          rd_data_d = '0;
          state_d   = VS_RESP;
        end else begin
          illegal_d = 1'b0;
          state_d   = VS_CALC;
        end
      end
      VS_CALC: begin
        vtype_d   = calc_vill ? {1'b1, {(XLEN-1){1'b0}}} : {{(XLEN-8){1'b0}}, vt};
        vl_d      = calc_vl;
        rd_data_d = calc_vl;
        state_d   = VS_WRITE;
      end
      VS_WRITE: state_d = VS_RESP;
      VS_RESP:  if (resp_ready_i) state_d = VS_IDLE;
      default:  state_d = VS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= VS_IDLE;
      kind_q    <= VSET_ILL;
      inst_q    <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      vtype_q   <= '0;
      vl_q      <= '0;
      rd_data_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      inst_q    <= inst_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      vtype_q   <= vtype_d;
      vl_q      <= vl_d;
      rd_data_q <= rd_data_d;
      illegal_q <= illegal_d;
    end
  end

  assign inst_ready_o = (state_q == VS_IDLE);
  assign csrwr_en     = (state_q == VS_WRITE);
  assign resp_valid_o = (state_q == VS_RESP);
  assign vtype_o      = vtype_q;
  assign vl_o         = vl_q;
  assign rd_data_o    = rd_data_q;
  assign rd_addr_o    = inst_q[11:7];
  assign illegal_o    = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_vec_vsetvl_unit.sv
// +-----------------------------------------------------------------------+
// | tb_vec_vsetvl_unit : table-driven bench with a response scoreboard    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_vec_vsetvl_unit;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [31:0] inst_i = '0, rs1_i = '0, rs2_i = '0, cur_vl_i = '0;
  logic        inst_valid_i = 1'b0, resp_ready_i = 1'b0;
  logic        inst_ready_o, csrwr_en, resp_valid_o, illegal_o;
  logic [31:0] vtype_o, vl_o, rd_data_o;
  logic [4:0]  rd_addr_o;

  int n_err = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  vec_vsetvl_unit #(.XLEN(32), .VLEN(512)) dut (
    .clk(clk), .n_rst(n_rst), .inst_i(inst_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o), .cur_vl_i(cur_vl_i),
    .vtype_o(vtype_o), .vl_o(vl_o), .csrwr_en(csrwr_en), .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i), .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o),
    .illegal_o(illegal_o)
  );

  typedef struct {
    logic [31:0] inst, rs1, rs2, cur_vl;
    logic [31:0] exp_vtype, exp_vl, exp_rd;
    logic [4:0]  exp_addr;
    logic        exp_ill;
    int          hold;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];

  function automatic logic [31:0] enc_vli(input logic [4:0] rd, input logic [4:0] rs1, input logic [10:0] zimm);
    return {1'b0, zimm, rs1, 3'b111, rd, 7'h57};
  endfunction

  function automatic logic [31:0] enc_ivli(input logic [4:0] rd, input logic [4:0] uimm, input logic [9:0] zimm);
    return {2'b11, zimm, uimm, 3'b111, rd, 7'h57};
  endfunction

  function automatic logic [31:0] enc_vl(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b1000000, rs2, rs1, 3'b111, rd, 7'h57};
  endfunction

  function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] cur_vl, input logic [31:0] vtype, input logic [31:0] vl,
                              input logic [31:0] rd, input logic [4:0] addr, input logic ill, input int hold);
    vec_t v;
    v.inst = inst; v.rs1 = rs1; v.rs2 = rs2; v.cur_vl = cur_vl;
    v.exp_vtype = vtype; v.exp_vl = vl; v.exp_rd = rd; v.exp_addr = addr;
    v.exp_ill = ill; v.hold = hold;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_one(input vec_t v);
    vec_t e;
    int   cyc, wr_cnt, wr_at;
    chk("ready_before", {31'b0, inst_ready_o}, 32'd1);
    inst_i = v.inst; rs1_i = v.rs1; rs2_i = v.rs2; cur_vl_i = v.cur_vl;
    inst_valid_i = 1'b1;
    sb_q.push_back(v);
    @(posedge clk); #1;
    // Operands must have been captured at accept, so scramble them afterwards.
    inst_valid_i = 1'b0;
    inst_i = $urandom; rs1_i = $urandom; rs2_i = $urandom;
    cyc = 1; wr_cnt = 0; wr_at = -1;
    while (!resp_valid_o && cyc < 20) begin
      if (csrwr_en) begin
        wr_cnt++;
        if (wr_at < 0) wr_at = cyc;
        chk("wr_vl", vl_o, sb_q[0].exp_vl);
        chk("wr_vtype", vtype_o, sb_q[0].exp_vtype);
      end
      @(posedge clk); #1;
      cyc++;
    end
    e = sb_q.pop_front();
    chk("resp_latency", cyc, e.exp_ill ? 32'd2 : 32'd4);
    chk("csrwr_count", wr_cnt, e.exp_ill ? 32'd0 : 32'd1);
    if (!e.exp_ill) chk("csrwr_latency", wr_at, 32'd3);
    chk("rd_data", rd_data_o, e.exp_rd);
    chk("rd_addr", {27'b0, rd_addr_o}, {27'b0, e.exp_addr});
    chk("illegal", {31'b0, illegal_o}, {31'b0, e.exp_ill});
    chk("vl_o", vl_o, e.exp_vl);
    chk("vtype_o", vtype_o, e.exp_vtype);
    chk("ready_busy", {31'b0, inst_ready_o}, 32'd0);
    for (int i = 0; i < e.hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, resp_valid_o}, 32'd1);
      chk("hold_data", rd_data_o, e.exp_rd);
      chk("hold_ready", {31'b0, inst_ready_o}, 32'd0);
      chk("hold_csrwr", {31'b0, csrwr_en}, 32'd0);
    end
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
    chk("idle_ready", {31'b0, inst_ready_o}, 32'd1);
    chk("idle_valid", {31'b0, resp_valid_o}, 32'd0);
  endtask

  initial begin
    int wr_seen;
    // inst, rs1, rs2, cur_vl, exp_vtype, exp_vl, exp_rd, exp_addr, exp_ill, hold
    tbl.push_back(mk(enc_vli(5'd5, 5'd6, 11'h010), 32'd10, 0, 0, 32'h10, 32'd10, 32'd10, 5'd5, 1'b0, 10));
    tbl.push_back(mk(enc_vli(5'd1, 5'd2, 11'h003), 32'd1000, 0, 0, 32'h03, 32'd512, 32'd512, 5'd1, 1'b0, 0));
    tbl.push_back(mk(enc_vli(5'd1, 5'd2, 11'h003), 32'd100, 0, 0, 32'h03, 32'd100, 32'd100, 5'd1, 1'b0, 0));
    tbl.push_back(mk(enc_vli(5'd7, 5'd0, 11'h019), 32'd999, 0, 0, 32'h19, 32'd16, 32'd16, 5'd7, 1'b0, 0));
    tbl.push_back(mk(enc_vli(5'd0, 5'd0, 11'h018), 32'd999, 0, 32'd16, 32'h18, 32'd8, 32'd8, 5'd0, 1'b0, 0));
    tbl.push_back(mk(enc_ivli(5'd3, 5'd5, 10'h0C8), 32'd77, 0, 0, 32'hC8, 32'd5, 32'd5, 5'd3, 1'b0, 0));
    tbl.push_back(mk(enc_ivli(5'd3, 5'd0, 10'h0C8), 32'd77, 0, 32'd9, 32'hC8, 32'd0, 32'd0, 5'd3, 1'b0, 0));
    tbl.push_back(mk(enc_vl(5'd4, 5'd6, 5'd7), 32'd50, 32'h20, 0, 32'h8000_0000, 32'd0, 32'd0, 5'd4, 1'b0, 0));
    tbl.push_back(mk(32'h00B5_0533, 32'd50, 32'h20, 0, 32'h8000_0000, 32'd0, 32'd0, 5'd10, 1'b1, 3));
    tbl.push_back(mk(enc_vl(5'd9, 5'd6, 5'd7), 32'd2000, 32'hC1, 0, 32'hC1, 32'd128, 32'd128, 5'd9, 1'b0, 0));
    tbl.push_back(mk(enc_vli(5'd2, 5'd6, 11'h005), 32'd3, 0, 0, 32'h8000_0000, 32'd0, 32'd0, 5'd2, 1'b0, 0));
    tbl.push_back(mk(enc_vli(5'd5, 5'd6, 11'h000), 32'd3, 0, 0, 32'h00, 32'd3, 32'd3, 5'd5, 1'b0, 0));
    tbl.push_back(mk(enc_vli(5'd2, 5'd6, 11'h110), 32'd3, 0, 0, 32'h8000_0000, 32'd0, 32'd0, 5'd2, 1'b0, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, inst_ready_o}, 32'd1);
    chk("rst_valid", {31'b0, resp_valid_o}, 32'd0);
    chk("rst_csrwr", {31'b0, csrwr_en}, 32'd0);
    chk("rst_vl", vl_o, 32'd0);
    chk("rst_vtype", vtype_o, 32'd0);
    chk("rst_rd", rd_data_o, 32'd0);
    chk("rst_ill", {31'b0, illegal_o}, 32'd0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) run_one(tbl[i]);

    // Reset asserted while in CALC must abort without a CSR write.
    inst_i = enc_vli(5'd5, 5'd6, 11'h010); rs1_i = 32'd10; inst_valid_i = 1'b1;
    @(posedge clk); #1;
    inst_valid_i = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b0;
    #1;
    chk("arst_ready", {31'b0, inst_ready_o}, 32'd1);
    chk("arst_valid", {31'b0, resp_valid_o}, 32'd0);
    chk("arst_csrwr", {31'b0, csrwr_en}, 32'd0);
    chk("arst_vl", vl_o, 32'd0);
    chk("arst_vtype", vtype_o, 32'd0);
    chk("arst_rd", rd_data_o, 32'd0);
    chk("arst_addr", {27'b0, rd_addr_o}, 32'd0);
    chk("arst_ill", {31'b0, illegal_o}, 32'd0);
    wr_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (csrwr_en) wr_seen++;
    end
    n_rst = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (csrwr_en) wr_seen++;
    end
    chk("arst_no_csrwr", wr_seen, 32'd0);
    chk("arst_idle", {31'b0, inst_ready_o}, 32'd1);

    run_one(tbl[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
